// File: rtl/anabellek_hakem.sv
// anabellek_hakem: two-requester round-robin arbiter in front of a single
// main-memory port. One transaction in flight at a time. A write completes
// when memory accepts it. A read completes when its response reaches the
// requester that owns it.
module anabellek_hakem #(
    parameter int ADRES_GENISLIK = 32,
    parameter int VERI_GENISLIK  = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    // requester 0
    input  logic [ADRES_GENISLIK-1:0] k0_istek_adres_i,
    input  logic [VERI_GENISLIK-1:0]  k0_istek_veri_i,
    input  logic                      k0_istek_gecerli_i,
    input  logic                      k0_istek_yaz_i,
    output logic                      k0_istek_hazir_o,
    output logic [VERI_GENISLIK-1:0]  k0_cevap_veri_o,
    output logic                      k0_cevap_gecerli_o,
    input  logic                      k0_cevap_hazir_i,

    // requester 1
    input  logic [ADRES_GENISLIK-1:0] k1_istek_adres_i,
    input  logic [VERI_GENISLIK-1:0]  k1_istek_veri_i,
    input  logic                      k1_istek_gecerli_i,
    input  logic                      k1_istek_yaz_i,
    output logic                      k1_istek_hazir_o,
    output logic [VERI_GENISLIK-1:0]  k1_cevap_veri_o,
    output logic                      k1_cevap_gecerli_o,
    input  logic                      k1_cevap_hazir_i,

    // main memory
    output logic [ADRES_GENISLIK-1:0] anabellek_istek_adres_o,
    output logic [VERI_GENISLIK-1:0]  anabellek_istek_veri_o,
    output logic                      anabellek_istek_gecerli_o,
    output logic                      anabellek_istek_yaz_gecerli_o,
    input  logic                      anabellek_istek_hazir_i,
    input  logic [VERI_GENISLIK-1:0]  anabellek_cevap_veri_i,
    input  logic                      anabellek_cevap_gecerli_i,
    output logic                      anabellek_cevap_hazir_o
);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,   // idle, waiting for a requester
        ISTEK = 2'd1,   // latched request presented to memory
        YANIT = 2'd2    // read issued, forwarding the response to the owner
    } durum_t;

    durum_t                    r_durum;
    durum_t                    w_durum_next;

    logic                      r_ptr;      // preferred requester on contention
    logic                      r_sahip;    // owner of the transaction in flight
    logic [ADRES_GENISLIK-1:0] r_adres;
    logic [VERI_GENISLIK-1:0]  r_veri;
    logic                      r_yaz;

    // Per-requester views so the per-requester logic can be generated
    logic [1:0]                w_gecerli;
    logic [1:0]                w_cevap_hazir;
    logic [1:0]                w_istek_hazir;
    logic [1:0]                w_cevap_gecerli;
    logic [VERI_GENISLIK-1:0]  w_cevap_veri [2];

    logic                      w_kazanan;
    logic                      w_kabul;
    logic                      w_mem_kabul;
    logic                      w_sahip_cevap_hazir;
    logic                      w_cevap_transfer;
    logic                      w_tamam;
    logic [ADRES_GENISLIK-1:0] w_sec_adres;
    logic [VERI_GENISLIK-1:0]  w_sec_veri;
    logic                      w_sec_yaz;

    assign w_gecerli     = {k1_istek_gecerli_i, k0_istek_gecerli_i};
    assign w_cevap_hazir = {k1_cevap_hazir_i, k0_cevap_hazir_i};

    // Winner: the only valid requester, or the pointer's choice when both are valid
    always_comb begin
        w_kazanan = 1'b0;
        if (&w_gecerli) begin
            w_kazanan = r_ptr;
        end else if (w_gecerli[1]) begin
            w_kazanan = 1'b1;
        end
    end

    // rst_i is folded in so that no ready is offered while reset is held.
    // The state register alone is not enough: it already reads BOSTA during reset.
    assign w_kabul     = rst_i && (r_durum == BOSTA) && (|w_gecerli);
    assign w_sec_adres = w_kazanan ? k1_istek_adres_i : k0_istek_adres_i;
    assign w_sec_veri  = w_kazanan ? k1_istek_veri_i  : k0_istek_veri_i;
    assign w_sec_yaz   = w_kazanan ? k1_istek_yaz_i   : k0_istek_yaz_i;

    assign w_mem_kabul         = (r_durum == ISTEK) && anabellek_istek_hazir_i;
    assign w_sahip_cevap_hazir = w_cevap_hazir[r_sahip];
    assign w_cevap_transfer    = (r_durum == YANIT) && anabellek_cevap_gecerli_i
                                 && w_sahip_cevap_hazir;
    assign w_tamam             = (w_mem_kabul && r_yaz) || w_cevap_transfer;

    // Per-requester grant and response routing; only the owner sees a response
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_istekci
            assign w_istek_hazir[gi]   = w_kabul && (w_kazanan == 1'(gi));
            assign w_cevap_gecerli[gi] = (r_durum == YANIT) && (r_sahip == 1'(gi))
                                         && anabellek_cevap_gecerli_i;
            assign w_cevap_veri[gi]    = ((r_durum == YANIT) && (r_sahip == 1'(gi)))
                                         ? anabellek_cevap_veri_i
                                         : '0;
        end
    endgenerate

    assign k0_istek_hazir_o   = w_istek_hazir[0];
    assign k1_istek_hazir_o   = w_istek_hazir[1];
    assign k0_cevap_gecerli_o = w_cevap_gecerli[0];
    assign k1_cevap_gecerli_o = w_cevap_gecerli[1];
    assign k0_cevap_veri_o    = w_cevap_veri[0];
    assign k1_cevap_veri_o    = w_cevap_veri[1];

    // Memory side: present the latched payload only while a request is pending
    assign anabellek_istek_gecerli_o     = (r_durum == ISTEK);
    assign anabellek_istek_yaz_gecerli_o = (r_durum == ISTEK) && r_yaz;
    assign anabellek_istek_adres_o       = (r_durum == ISTEK) ? r_adres : '0;
    assign anabellek_istek_veri_o        = (r_durum == ISTEK) ? r_veri  : '0;
    assign anabellek_cevap_hazir_o       = (r_durum == YANIT) && w_sahip_cevap_hazir;

    // Next-state logic; a write never waits for a response
    always_comb begin
        w_durum_next = r_durum;
        case (r_durum)
            BOSTA: begin
                if (w_kabul) begin
                    w_durum_next = ISTEK;
                end
            end
            ISTEK: begin
                if (w_mem_kabul) begin
                    w_durum_next = r_yaz ? BOSTA : YANIT;
                end
            end
            YANIT: begin
                if (w_cevap_transfer) begin
                    w_durum_next = BOSTA;
                end
            end
            default: w_durum_next = BOSTA;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_durum_next;
        end
    end

    // Round-robin pointer hands priority to the other requester after each completion
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ptr <= 1'b0;
        end else if (w_tamam) begin
            r_ptr <= ~r_sahip;
        end
    end

    // Holding registers capture the winner's request on the accept edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sahip <= 1'b0;
            r_adres <= '0;
            r_veri  <= '0;
            r_yaz   <= 1'b0;
        end else if (w_kabul) begin
            r_sahip <= w_kazanan;
            r_adres <= w_sec_adres;
            r_veri  <= w_sec_veri;
            r_yaz   <= w_sec_yaz;
        end
    end

endmodule

// File: tb/tb_anabellek_hakem.sv
// Directed bench for anabellek_hakem. The bench plays both requesters and
// main memory by hand. Each check is an immediate assertion.
module tb_anabellek_hakem;

    localparam int AW = 32;
    localparam int DW = 128;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] k0_istek_adres_i, k1_istek_adres_i;
    logic [DW-1:0] k0_istek_veri_i, k1_istek_veri_i;
    logic          k0_istek_gecerli_i, k1_istek_gecerli_i;
    logic          k0_istek_yaz_i, k1_istek_yaz_i;
    logic          k0_istek_hazir_o, k1_istek_hazir_o;
    logic [DW-1:0] k0_cevap_veri_o, k1_cevap_veri_o;
    logic          k0_cevap_gecerli_o, k1_cevap_gecerli_o;
    logic          k0_cevap_hazir_i, k1_cevap_hazir_i;
    logic [AW-1:0] anabellek_istek_adres_o;
    logic [DW-1:0] anabellek_istek_veri_o;
    logic          anabellek_istek_gecerli_o, anabellek_istek_yaz_gecerli_o;
    logic          anabellek_istek_hazir_i;
    logic [DW-1:0] anabellek_cevap_veri_i;
    logic          anabellek_cevap_gecerli_i;
    logic          anabellek_cevap_hazir_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] mem_40;   // block the memory holds at 0x40 after scenario 1

    always #5 clk_i = ~clk_i;

    anabellek_hakem #(.ADRES_GENISLIK(AW), .VERI_GENISLIK(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .k0_istek_adres_i(k0_istek_adres_i), .k0_istek_veri_i(k0_istek_veri_i),
        .k0_istek_gecerli_i(k0_istek_gecerli_i), .k0_istek_yaz_i(k0_istek_yaz_i),
        .k0_istek_hazir_o(k0_istek_hazir_o), .k0_cevap_veri_o(k0_cevap_veri_o),
        .k0_cevap_gecerli_o(k0_cevap_gecerli_o), .k0_cevap_hazir_i(k0_cevap_hazir_i),
        .k1_istek_adres_i(k1_istek_adres_i), .k1_istek_veri_i(k1_istek_veri_i),
        .k1_istek_gecerli_i(k1_istek_gecerli_i), .k1_istek_yaz_i(k1_istek_yaz_i),
        .k1_istek_hazir_o(k1_istek_hazir_o), .k1_cevap_veri_o(k1_cevap_veri_o),
        .k1_cevap_gecerli_o(k1_cevap_gecerli_o), .k1_cevap_hazir_i(k1_cevap_hazir_i),
        .anabellek_istek_adres_o(anabellek_istek_adres_o),
        .anabellek_istek_veri_o(anabellek_istek_veri_o),
        .anabellek_istek_gecerli_o(anabellek_istek_gecerli_o),
        .anabellek_istek_yaz_gecerli_o(anabellek_istek_yaz_gecerli_o),
        .anabellek_istek_hazir_i(anabellek_istek_hazir_i),
        .anabellek_cevap_veri_i(anabellek_cevap_veri_i),
        .anabellek_cevap_gecerli_i(anabellek_cevap_gecerli_i),
        .anabellek_cevap_hazir_o(anabellek_cevap_hazir_o)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step just past the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Checks that every output reads 0, as it must while reset is low
    task automatic chk_all_zero(input string tag);
        chk({tag, "_k0hz"}, DW'(k0_istek_hazir_o), '0);
        chk({tag, "_k1hz"}, DW'(k1_istek_hazir_o), '0);
        chk({tag, "_k0cg"}, DW'(k0_cevap_gecerli_o), '0);
        chk({tag, "_k1cg"}, DW'(k1_cevap_gecerli_o), '0);
        chk({tag, "_k0cv"}, k0_cevap_veri_o, '0);
        chk({tag, "_k1cv"}, k1_cevap_veri_o, '0);
        chk({tag, "_mg"}, DW'(anabellek_istek_gecerli_o), '0);
        chk({tag, "_my"}, DW'(anabellek_istek_yaz_gecerli_o), '0);
        chk({tag, "_ma"}, DW'(anabellek_istek_adres_o), '0);
        chk({tag, "_mv"}, anabellek_istek_veri_o, '0);
        chk({tag, "_mch"}, DW'(anabellek_cevap_hazir_o), '0);
    endtask

    // Runs one read with both requesters valid: grant, memory issue, response
    task automatic rr_read(input int idx, input logic exp_own);
        logic [AW-1:0] exp_adr;
        logic [DW-1:0] rdata;
        exp_adr = exp_own ? 32'h200 : 32'h100;
        rdata   = {96'h0, 32'hD0D0_0000 + 32'(idx)};
        $display("rr read %0d: expecting grant to k%0d", idx, exp_own);
        chk($sformatf("rr%0d_k0hz", idx), DW'(k0_istek_hazir_o), DW'(!exp_own));
        chk($sformatf("rr%0d_k1hz", idx), DW'(k1_istek_hazir_o), DW'(exp_own));
        step();
        chk($sformatf("rr%0d_madr", idx), DW'(anabellek_istek_adres_o), DW'(exp_adr));
        chk($sformatf("rr%0d_mg", idx), DW'(anabellek_istek_gecerli_o), DW'(1));
        anabellek_istek_hazir_i = 1'b1;
        step();
        anabellek_istek_hazir_i   = 1'b0;
        anabellek_cevap_veri_i    = rdata;
        anabellek_cevap_gecerli_i = 1'b1;
        #1;
        chk($sformatf("rr%0d_owncg", idx),
            DW'(exp_own ? k1_cevap_gecerli_o : k0_cevap_gecerli_o), DW'(1));
        chk($sformatf("rr%0d_othcg", idx),
            DW'(exp_own ? k0_cevap_gecerli_o : k1_cevap_gecerli_o), '0);
        chk($sformatf("rr%0d_ownv", idx),
            exp_own ? k1_cevap_veri_o : k0_cevap_veri_o, rdata);
        step();
        anabellek_cevap_gecerli_i = 1'b0;
        #1;
    endtask

    initial begin
        // Reset, with k0 already valid: no ready may be offered
        rst_i = 1'b0;
        k0_istek_adres_i = '0; k0_istek_veri_i = '0; k0_istek_gecerli_i = 1'b0; k0_istek_yaz_i = 1'b0;
        k1_istek_adres_i = '0; k1_istek_veri_i = '0; k1_istek_gecerli_i = 1'b0; k1_istek_yaz_i = 1'b0;
        k0_cevap_hazir_i = 1'b1; k1_cevap_hazir_i = 1'b1;
        anabellek_istek_hazir_i = 1'b0; anabellek_cevap_veri_i = '0; anabellek_cevap_gecerli_i = 1'b0;
        mem_40 = '0;
        #2;
        k0_istek_gecerli_i = 1'b1;
        #1;
        chk_all_zero("rst");

        // Scenario 1: k0 writes 0xABCD0040 to 0x40, accepted on first edge after reset release
        #9;  // t=12, between edges
        rst_i = 1'b1;
        k0_istek_adres_i = 32'h40; k0_istek_veri_i = 128'hABCD0040; k0_istek_yaz_i = 1'b1;
        #1;
        $display("s1: k0 write 0x40");
        chk("s1_k0hz", DW'(k0_istek_hazir_o), DW'(1));
        chk("s1_k1hz", DW'(k1_istek_hazir_o), '0);
        step();
        k0_istek_gecerli_i = 1'b0;
        #1;
        chk("s1_mg", DW'(anabellek_istek_gecerli_o), DW'(1));
        chk("s1_my", DW'(anabellek_istek_yaz_gecerli_o), DW'(1));
        chk("s1_madr", DW'(anabellek_istek_adres_o), DW'(32'h40));
        chk("s1_mdat", anabellek_istek_veri_o, 128'hABCD0040);
        chk("s1_k0hz_busy", DW'(k0_istek_hazir_o), '0);
        anabellek_istek_hazir_i = 1'b1;
        step();
        mem_40 = 128'hABCD0040;
        anabellek_istek_hazir_i = 1'b0;
        #1;
        chk("s1_mg_done", DW'(anabellek_istek_gecerli_o), '0);
        chk("s1_k0cg", DW'(k0_cevap_gecerli_o), '0);
        chk("s1_k1cg", DW'(k1_cevap_gecerli_o), '0);

        // Scenario 2: k1 reads 0x40 and receives the stored block
        k1_istek_adres_i = 32'h40; k1_istek_yaz_i = 1'b0; k1_istek_gecerli_i = 1'b1;
        #1;
        $display("s2: k1 read 0x40");
        chk("s2_k1hz", DW'(k1_istek_hazir_o), DW'(1));
        chk("s2_k0hz", DW'(k0_istek_hazir_o), '0);
        step();
        k1_istek_gecerli_i = 1'b0;
        #1;
        chk("s2_mg", DW'(anabellek_istek_gecerli_o), DW'(1));
        chk("s2_my", DW'(anabellek_istek_yaz_gecerli_o), '0);
        chk("s2_madr", DW'(anabellek_istek_adres_o), DW'(32'h40));
        anabellek_istek_hazir_i = 1'b1;
        step();
        anabellek_istek_hazir_i   = 1'b0;
        anabellek_cevap_veri_i    = mem_40;
        anabellek_cevap_gecerli_i = 1'b1;
        #1;
        chk("s2_mg_done", DW'(anabellek_istek_gecerli_o), '0);
        chk("s2_k1cg", DW'(k1_cevap_gecerli_o), DW'(1));
        chk("s2_k1cv", k1_cevap_veri_o, 128'hABCD0040);
        chk("s2_k0cg", DW'(k0_cevap_gecerli_o), '0);
        chk("s2_mch", DW'(anabellek_cevap_hazir_o), DW'(1));
        step();
        // Back in idle: a lingering memory response is ignored
        chk("s2_idle_k1cg", DW'(k1_cevap_gecerli_o), '0);
        chk("s2_idle_mch", DW'(anabellek_cevap_hazir_o), '0);
        anabellek_cevap_gecerli_i = 1'b0;

        // Scenario 3: both valid from reset, four reads alternate k0,k1,k0,k1
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
        k0_istek_adres_i = 32'h100; k0_istek_yaz_i = 1'b0; k0_istek_gecerli_i = 1'b1;
        k1_istek_adres_i = 32'h200; k1_istek_yaz_i = 1'b0; k1_istek_gecerli_i = 1'b1;
        #1;
        rr_read(0, 1'b0);
        rr_read(1, 1'b1);
        rr_read(2, 1'b0);
        rr_read(3, 1'b1);

        // Scenario 4: memory stalls 5 cycles; request held stable, no new accept
        k0_istek_adres_i = 32'h80; k0_istek_veri_i = 128'h1234_5678_9ABC; k0_istek_yaz_i = 1'b1;
        #1;
        $display("s4: k0 write 0x80 with memory stall");
        chk("s4_k0hz", DW'(k0_istek_hazir_o), DW'(1));
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("s4_c%0d_mg", c), DW'(anabellek_istek_gecerli_o), DW'(1));
            chk($sformatf("s4_c%0d_madr", c), DW'(anabellek_istek_adres_o), DW'(32'h80));
            chk($sformatf("s4_c%0d_mdat", c), anabellek_istek_veri_o, 128'h1234_5678_9ABC);
            chk($sformatf("s4_c%0d_hz", c), DW'({k1_istek_hazir_o, k0_istek_hazir_o}), '0);
            step();
        end
        anabellek_istek_hazir_i = 1'b1;
        step();
        anabellek_istek_hazir_i = 1'b0;
        k0_istek_gecerli_i = 1'b0;
        #1;
        chk("s4_mg_done", DW'(anabellek_istek_gecerli_o), '0);

        // Scenario 5: owner k1 not ready for 3 cycles during the response
        k1_istek_adres_i = 32'h300; k1_istek_yaz_i = 1'b0;
        #1;
        $display("s5: k1 read 0x300 with response backpressure");
        chk("s5_k1hz", DW'(k1_istek_hazir_o), DW'(1));
        step();
        k1_istek_gecerli_i = 1'b0;
        anabellek_istek_hazir_i = 1'b1;
        step();
        anabellek_istek_hazir_i   = 1'b0;
        k1_cevap_hazir_i          = 1'b0;
        anabellek_cevap_veri_i    = 128'h55AA_0300;
        anabellek_cevap_gecerli_i = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("s5_c%0d_mch", c), DW'(anabellek_cevap_hazir_o), '0);
            chk($sformatf("s5_c%0d_k1cg", c), DW'(k1_cevap_gecerli_o), DW'(1));
            chk($sformatf("s5_c%0d_k1cv", c), k1_cevap_veri_o, 128'h55AA_0300);
            step();
        end
        k1_cevap_hazir_i = 1'b1;
        #1;
        chk("s5_mch", DW'(anabellek_cevap_hazir_o), DW'(1));
        step();
        chk("s5_done_k1cg", DW'(k1_cevap_gecerli_o), '0);
        anabellek_cevap_gecerli_i = 1'b0;

        // Scenario 6: reset mid-request clears outputs at once; k1 accepted on first edge after
        k0_istek_adres_i = 32'h500; k0_istek_yaz_i = 1'b1; k0_istek_gecerli_i = 1'b1;
        #1;
        $display("s6: reset during ISTEK");
        step();
        k0_istek_gecerli_i = 1'b0;
        #1;
        chk("s6_mg_pre", DW'(anabellek_istek_gecerli_o), DW'(1));
        k1_istek_adres_i = 32'h600; k1_istek_yaz_i = 1'b0; k1_istek_gecerli_i = 1'b1;
        #1;
        rst_i = 1'b0;
        #1;
        chk_all_zero("s6");
        #1;
        rst_i = 1'b1;
        #1;
        chk("s6_k1hz", DW'(k1_istek_hazir_o), DW'(1));
        step();
        chk("s6_mg", DW'(anabellek_istek_gecerli_o), DW'(1));
        chk("s6_madr", DW'(anabellek_istek_adres_o), DW'(32'h600));
        chk("s6_my", DW'(anabellek_istek_yaz_gecerli_o), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
